// File: rtl/popcount_expand.sv
// rtl/popcount_expand.sv - count to thermometer-vector expander, CHUNK bits per cycle (optional self-check: POPCOUNT_EXPAND_CHECK_EN)
module popcount_expand #(
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         areset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [254:0] out,
    output logic [7:0]   out_count,
    output logic         err
);

    localparam int NCHUNK = (255 + CHUNK - 1) / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [7:0] CHUNK_W = 8'(CHUNK);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      rem;
    logic [IDXW-1:0] idx;
    logic [7:0]      base;
    logic [7:0]      width;
    logic [7:0]      n;
    logic [255:0]    ones;
    logic [254:0]    mask;
    logic            last;
    logic            accept;

    assign accept = in_valid && (state == IDLE);

    // Ones to write this FILL cycle: n = min(rem, width of current chunk), placed at the chunk base
    always_comb begin
        base  = 8'(int'(idx) * CHUNK);
        last  = (idx == LAST_IDX);
        width = last ? (8'd255 - base) : CHUNK_W;
        n     = (rem < width) ? rem : width;
        ones  = (256'd1 << n) - 256'd1;
        mask  = ones[254:0] << base;
    end

    // State register
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready/out_valid depend on state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = FILL;
            end
            FILL: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector build: cleared at accept, one chunk OR-ed in per FILL cycle, held otherwise
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            out       <= '0;
            out_count <= '0;
            rem       <= '0;
            idx       <= '0;
        end else if (accept) begin
            out       <= '0;
            out_count <= count;
            rem       <= count;
            idx       <= '0;
        end else if (state == FILL) begin
            out <= out | mask;
            rem <= rem - n;
            idx <= last ? '0 : idx + IDXW'(1);
        end
    end

`ifdef POPCOUNT_EXPAND_CHECK_EN
    logic [8:0] acc;

    // Independent tally of written ones, compared with the latched count as DONE is entered
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            acc <= '0;
            err <= 1'b0;
        end else if (accept) begin
            acc <= '0;
        end else if (state == FILL) begin
            acc <= acc + {1'b0, n};
            if (last && ((acc + {1'b0, n}) != {1'b0, out_count})) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_popcount_expand.sv
// tb/tb_popcount_expand.sv - self-checking bench for popcount_expand against a thermometer reference model
module tb_popcount_expand;

    localparam int CHUNK   = 16;
    localparam int NCHUNK  = (255 + CHUNK - 1) / CHUNK;
    localparam int CHUNK_B = 7;
    localparam int NCHUNK_B = (255 + CHUNK_B - 1) / CHUNK_B;

    logic         clk = 1'b0;
    logic         areset_n;
    logic         in_valid, in_ready, out_valid, out_ready, err;
    logic [7:0]   count, out_count;
    logic [254:0] out;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err;
    logic [7:0]   b_count, b_out_count;
    logic [254:0] b_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    popcount_expand #(.CHUNK(CHUNK)) dut (
        .clk(clk), .areset_n(areset_n),
        .in_valid(in_valid), .in_ready(in_ready), .count(count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_count(out_count), .err(err)
    );

    popcount_expand #(.CHUNK(CHUNK_B)) dut_b (
        .clk(clk), .areset_n(areset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .count(b_count),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out(b_out), .out_count(b_out_count), .err(b_err)
    );

    function automatic logic [254:0] thermo(input int c);
        logic [254:0] v;
        v = '0;
        for (int i = 0; i < c; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int popcnt(input logic [254:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 255; i++) s += int'(v[i]);
        return s;
    endfunction

    task automatic chk_vec(input string tag, input logic [254:0] obs, input logic [254:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for the result, check it, hold it under backpressure, then hand it off
    task automatic finish_xfer(input int c, input int hold);
        int lat;
        lat = 0;
        while (!out_valid && lat < 1000) begin
            step();
            lat++;
        end
        chk_int("latency", lat, NCHUNK);
        chk_vec("out", out, thermo(c));
        chk_int("out_count", int'(out_count), c);
        chk_int("popcount", popcnt(out), c);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            step();
            chk_int("hold_valid", int'(out_valid), 1);
            chk_int("hold_in_ready", int'(in_ready), 0);
            chk_vec("hold_out", out, thermo(c));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_int("valid_drop", int'(out_valid), 0);
        chk_int("ready_back", int'(in_ready), 1);
        chk_vec("out_kept", out, thermo(c));
    endtask

    task automatic xfer(input int c, input int hold);
        int w;
        w = 0;
        while (!in_ready && w < 1000) begin
            step();
            w++;
        end
        chk_int("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        count    = 8'(c);
        step();
        in_valid = 1'b0;
        count    = 8'($urandom_range(255, 0));
        finish_xfer(c, hold);
    endtask

    initial begin
        int lat;
        areset_n = 1'b0;
        in_valid = 1'b0;  count = '0;  out_ready = 1'b0;
        b_in_valid = 1'b0; b_count = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        areset_n = 1'b1;
        #1;
        chk_vec("rst_out", out, '0);
        chk_int("rst_out_count", int'(out_count), 0);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_int("rst_err", int'(err), 0);
        chk_int("rst_in_ready", int'(in_ready), 1);

        // Reset during FILL discards the partial vector
        in_valid = 1'b1;
        count    = 8'd200;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk_vec("partial_out", out, thermo(5 * CHUNK));
        areset_n = 1'b0;
        #1;
        chk_vec("abort_out", out, '0);
        chk_int("abort_out_valid", int'(out_valid), 0);
        chk_int("abort_out_count", int'(out_count), 0);
        chk_int("abort_err", int'(err), 0);
        step();
        areset_n = 1'b1;
        #1;
        chk_int("abort_in_ready", int'(in_ready), 1);

        // Boundary counts
        xfer(0, 0);
        xfer(255, 1);
        xfer(17, 0);
        chk_vec("c17_value", out, 255'h1FFFF);

        // Back-to-back with in_valid held: extra requests during FILL/DONE are ignored
        in_valid = 1'b1;
        count    = 8'd8;
        step();
        count    = 8'd100;
        lat = 0;
        while (!out_valid && lat < 1000) begin
            step();
            lat++;
        end
        chk_int("b2b_latency", lat, NCHUNK);
        for (int h = 0; h < 10; h++) begin
            step();
            chk_vec("b2b_hold_out", out, 255'hFF);
            chk_int("b2b_hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_int("b2b_idle_valid", int'(out_valid), 0);
        chk_int("b2b_idle_count", int'(out_count), 8);
        step();
        in_valid = 1'b0;
        chk_int("b2b_accept_count", int'(out_count), 100);
        chk_int("b2b_accept_in_ready", int'(in_ready), 0);
        finish_xfer(100, 0);

        // Randomized counts with random backpressure
        for (int k = 0; k < 200; k++) begin
            xfer(int'($urandom_range(255, 0)), int'($urandom_range(3, 0)));
        end
        chk_int("err_after_random", int'(err), 0);

        // CHUNK=7 instance: 37 chunks, ragged last chunk
        b_in_valid = 1'b1;
        b_count    = 8'd254;
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 1000) begin
            step();
            lat++;
        end
        chk_int("c7_latency", lat, NCHUNK_B);
        chk_vec("c7_out", b_out, thermo(254));
        chk_int("c7_out_count", int'(b_out_count), 254);
        chk_int("c7_err", int'(b_err), 0);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        chk_int("c7_ready_back", int'(b_in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/popcount_expand.md
# popcount_expand

Sequential inverse of the 255-bit population counter. Accepts an 8-bit count over a valid/ready handshake and builds a 255-bit thermometer vector with exactly that many ones, packed from bit 0 upward. The vector is built CHUNK bits per cycle and presented on a valid/ready output port. It sits in the stimulus/loopback path ahead of the popcount unit, so that popcount(out) == count end to end.

## Interface
- CHUNK, 16, bits filled per FILL cycle; legal range 1..255. NCHUNK = ceil(255/CHUNK); the last chunk is clipped at bit 254.
- clk  input  1  rising-edge clock
- areset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  count request valid
- in_ready  output  1  block can accept a count
- count  input  8  requested number of ones, 0..255
- out_valid  output  1  out holds a finished vector
- out_ready  input  1  consumer takes the vector
- out  output  255  thermometer vector; bits [count-1:0] = 1, all other bits 0
- out_count  output  8  latched copy of the accepted count
- err  output  1  sticky self-check failure flag (see Configuration)

## Operation
- Reset values: state IDLE; out=0; out_count=0; out_valid=0; err=0. in_ready=1 once areset_n is high.
- Three states: IDLE, FILL, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: latch count into out_count and into rem; clear out to 0; set idx=0; go to FILL.
- FILL:
  - in_ready=0, out_valid=0.
  - Each cycle, n = min(rem, width of chunk idx), where chunk width is CHUNK, or 255-idx*CHUNK for the last chunk.
  - Set the n lowest bits of slice idx to 1; rem -= n; idx++.
  - After chunk NCHUNK-1, go to DONE.
  - Every chunk is processed even once rem reaches 0, so latency is fixed.
- DONE:
  - out_valid=1, out stable.
  - On out_ready, go to IDLE. out keeps its value until the next accept.
- Arithmetic:
  - rem and n are 8 bits wide; the rem -= n subtraction never underflows.
  - idx is clog2(NCHUNK) bits wide.
  - count=0 gives all zeros; count=255 gives all 255 bits set.
- in_valid outside IDLE is ignored, with no buffering. count is sampled only at the handshake.
- Reset asserted mid-FILL or in DONE aborts the operation immediately. All outputs return to their reset values, and the partial vector is discarded.

## Timing
- Accept edge E0 (in_valid & in_ready) → FILL on edges E1..E_NCHUNK → out_valid=1 after edge E_NCHUNK. Latency is NCHUNK cycles (16 at default).
- DONE with out_ready high returns to IDLE at the next edge. The earliest next accept is the edge after that.
- Throughput is one vector per NCHUNK+2 cycles. in_ready is combinational from state only.
- out_valid drops the cycle after the out_ready handshake.
- out changes only during FILL and at the accept edge.

## Configuration
- POPCOUNT_EXPAND_CHECK_EN defined:
  - A 9-bit accumulator clears at accept and adds the number of ones written in each FILL cycle.
  - On entry to DONE, if accumulator != out_count, err is set.
  - err is sticky until areset_n.
  - The checker adds no latency.
- Not defined: err is tied to 0 and no checker logic is present.

## Test plan
- Reset mid-FILL: accept count=200, assert areset_n low after 5 FILL cycles → out=0, out_valid=0, err=0; after release, in_ready=1.
- count=0 and count=255 in turn → out=0 after 16 cycles; then out equals all 255 bits set. out_count echoes each count.
- count=17, CHUNK=16 → out = 0x1FFFF (bits 16:0 set). out_valid rises exactly 16 cycles after the accept edge.
- Back-to-back: hold in_valid=1 with counts 8, 100, hold out_ready=0 for 10 cycles in DONE → out stays 0xFF and in_ready stays 0. After out_ready, the next accept of 100 happens 2 edges later.
- CHUNK=7 build, count=254 → all bits except bit 254 set. NCHUNK=37, with latency 37 cycles.
- 200 random counts with random out_ready backpressure; compare popcount(out)==out_count and out==(1<<count)-1. With POPCOUNT_EXPAND_CHECK_EN defined, err stays 0 throughout.
